iddmm_host_if: RTL and testbench
================================

// Module: iddmm_host_if
// PURPOSE
//  Host-side initiator for the iddmm_top Montgomery multiplier (result = x*y*r^-1 mod m).
//  Accepts one job as N parallel K-bit operand words on a valid/ready stream and writes them
//  into the multiplier's x/y/m RAMs. Issues task_req, captures the N result words the
//  multiplier streams back, and replays them downstream with valid/ready backpressure.
// PARAMETERS
//  K       128           bits per word
//  N       32            words per operand
//  ADDR_W  $clog2(N)     word address width
//  TMO     4096          max cycles from task_req to task_end before timeout
// PORTS
//  clk            in   1       clock; all logic on rising edge
//  rst            in   1       reset, synchronous, active-high
//  s_valid        in   1       operand word valid
//  s_ready        out  1       operand word accepted when s_valid&s_ready
//  s_x/s_y/s_m    in   K each  operand words, least-significant word first
//  s_m1           in   K       Montgomery constant -m^-1 mod 2^K; sampled on word 0 only
//  s_keep_m       in   1       sampled on word 0: 1 = modulus RAM already loaded, skip m writes
//  mm_wr_ena      out  3       {m,y,x} write enables to multiplier
//  mm_wr_addr     out  ADDR_W  write word address
//  mm_wr_x/y/m    out  K each  write data
//  mm_wr_m1       out  K       held m1 for the whole job
//  mm_task_req    out  1       single-cycle start pulse
//  mm_task_grant  in   1       result word valid on mm_task_res this cycle
//  mm_task_end    in   1       coincides with final result word
//  mm_task_res    in   K       result word, LSW first
//  m_valid/m_ready  out/in 1   result stream handshake
//  m_data         out  K       result word
//  m_last         out  1       high with word N-1
//  busy           out  1       state != IDLE
//  err_timeout    out  1       sticky; cleared on next word-0 accept
// BEHAVIOUR
//  Reset: all outputs 0, except s_ready=1 (IDLE). m1/keep_m regs, counters, FSM to IDLE.
//   Reset mid-job discards all state; next job restarts at address 0.
//  FSM: IDLE -> LOAD -> REQ -> WAIT -> DRAIN -> IDLE.
//  IDLE/LOAD: s_ready=1. Accept at cycle t -> mm_wr_ena/addr/data registered at t+1
//   (ena = {~keep_m,1,1}); ena low in cycles without an accept. wcnt counts 0..N-1;
//   the accept of word 0 latches m1, keep_m and clears err_timeout. Accept of word N-1 -> REQ.
//  REQ: s_ready=0; mm_task_req=1 for exactly one cycle, the cycle after the last write.
//   -> WAIT, timer cleared.
//  WAIT: each mm_task_grant writes mm_task_res into result buffer[rcnt], rcnt++.
//   mm_task_end -> DRAIN (word stored the same cycle).
//   Grant while not in WAIT is ignored. Timer reaches TMO without end -> err_timeout=1,
//   buffer discarded, -> IDLE.
//  DRAIN: m_valid=1, m_data=buffer[ocnt], m_last=(ocnt==N-1). Data held stable while
//   m_valid&!m_ready. Handshake on N-1 -> IDLE, s_ready=1 next cycle.
//  Result buffer: N x K storage, registered read; zero-bubble output when m_ready held high.
//  Counters wrap only via explicit clear at job start; end with rcnt!=N-1 still drains
//   rcnt+1 words with m_last on the final one.
// TESTING (bench K=16, N=4, TMO=16; model of multiplier returns scripted words)
//  1. Assert rst 2 cycles -> s_ready=1, all other outputs 0, busy=0.
//  2. 4 back-to-back words x=1..4, y=5..8, m=9..C, m1=0x33 -> addr 0,1,2,3 on
//     consecutive cycles, ena=3'b111, mm_wr_m1=0x33, one task_req the cycle after addr 3.
//  3. Same job with s_keep_m=1 -> ena=3'b011 for all 4 writes; m RAM untouched.
//  4. Model returns A0..A3 (end with A3) while m_ready=0; then m_ready toggles ->
//     m_data A0,A1,A2,A3 in order, stable when stalled, m_last only with A3, then IDLE.
//  5. Model never responds -> err_timeout=1 at task_req+16, s_ready=1.
//     Next word-0 accept clears err_timeout.
//  6. rst after 2 words of a load -> outputs 0. New job writes addr 0..3;
//     stray grant in IDLE leaves m_valid=0.

Source files
------------

// File: rtl/iddmm_host_if.sv
// iddmm_host_if
// Host-side initiator for the iddmm_top Montgomery multiplier.
// A job arrives as N operand words (x, y, m in parallel, LSW first) on a
// valid/ready stream. Each accepted word is written into the multiplier RAMs
// one cycle later. After the last write a single-cycle task_req starts the
// multiplier. The result words it streams back are buffered, then replayed
// downstream with valid/ready backpressure. A watchdog aborts a job whose
// task_end does not arrive within TMO cycles of task_req.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   s_valid/s_ready           operand stream handshake
//   s_x/s_y/s_m               operand words
//   s_m1, s_keep_m            per-job settings, sampled on word 0 only
//   mm_wr_ena/addr/x/y/m/m1   multiplier RAM write port ({m,y,x} enables)
//   mm_task_req               start pulse
//   mm_task_grant/end/res     multiplier result stream
//   m_valid/m_ready/m_data    result stream
//   m_last                    marks the final result word
//   busy                      job in progress
//   err_timeout               sticky watchdog flag, cleared by next word 0
module iddmm_host_if #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N),
  parameter int TMO    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [K-1:0]      s_x,
  input  logic [K-1:0]      s_y,
  input  logic [K-1:0]      s_m,
  input  logic [K-1:0]      s_m1,
  input  logic              s_keep_m,
  output logic [2:0]        mm_wr_ena,
  output logic [ADDR_W-1:0] mm_wr_addr,
  output logic [K-1:0]      mm_wr_x,
  output logic [K-1:0]      mm_wr_y,
  output logic [K-1:0]      mm_wr_m,
  output logic [K-1:0]      mm_wr_m1,
  output logic              mm_task_req,
  input  logic              mm_task_grant,
  input  logic              mm_task_end,
  input  logic [K-1:0]      mm_task_res,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [K-1:0]      m_data,
  output logic              m_last,
  output logic              busy,
  output logic              err_timeout
);

  localparam int TW = $clog2(TMO + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t              state_q;
  logic                s_ready_q;
  logic [2:0]          mm_wr_ena_q;
  logic [ADDR_W-1:0]   mm_wr_addr_q;
  logic [K-1:0]        mm_wr_x_q;
  logic [K-1:0]        mm_wr_y_q;
  logic [K-1:0]        mm_wr_m_q;
  logic [K-1:0]        m1_q;
  logic                keep_q;
  logic                mm_task_req_q;
  logic                m_valid_q;
  logic [K-1:0]        m_data_q;
  logic                m_last_q;
  logic                busy_q;
  logic                err_q;
  logic [ADDR_W-1:0]   wcnt_q;
  logic [ADDR_W-1:0]   rcnt_q;
  logic [ADDR_W-1:0]   ocnt_q;
  logic [ADDR_W-1:0]   last_q;
  logic [TW-1:0]       timer_q;
  logic [K-1:0]        buf_q [N];

  logic                accept;
  logic                keep_now;
  logic                buf_we;
  logic [ADDR_W-1:0]   ocnt_nxt;

  assign accept   = s_valid & s_ready_q;
  // keep_m is live on word 0 and comes from the latched copy afterwards
  assign keep_now = (wcnt_q == '0) ? s_keep_m : keep_q;
  // Grants outside WAIT are stray and must not touch the buffer
  assign buf_we   = (state_q == WAIT) & mm_task_grant;
  assign ocnt_nxt = ocnt_q + ONE_IDX;

  // Result buffer: written by multiplier grants, read through m_data_q
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[rcnt_q] <= mm_task_res;
    end
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      s_ready_q     <= 1'b1;
      mm_wr_ena_q   <= 3'b000;
      mm_wr_addr_q  <= '0;
      mm_wr_x_q     <= '0;
      mm_wr_y_q     <= '0;
      mm_wr_m_q     <= '0;
      m1_q          <= '0;
      keep_q        <= 1'b0;
      mm_task_req_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      wcnt_q        <= '0;
      rcnt_q        <= '0;
      ocnt_q        <= '0;
      last_q        <= '0;
      timer_q       <= '0;
    end else begin
      // Write enables and the start pulse are single-cycle strobes
      mm_wr_ena_q   <= 3'b000;
      mm_task_req_q <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            mm_wr_ena_q  <= {~keep_now, 2'b11};
            mm_wr_addr_q <= wcnt_q;
            mm_wr_x_q    <= s_x;
            mm_wr_y_q    <= s_y;
            mm_wr_m_q    <= s_m;
            busy_q       <= 1'b1;
            if (wcnt_q == '0) begin
              m1_q   <= s_m1;
              keep_q <= s_keep_m;
              err_q  <= 1'b0;
            end
            if (wcnt_q == LAST_IDX) begin
              wcnt_q    <= '0;
              s_ready_q <= 1'b0;
              state_q   <= REQ;
            end else begin
              wcnt_q  <= wcnt_q + ONE_IDX;
              state_q <= LOAD;
            end
          end
        end
        REQ: begin
          // One cycle after the last write has been presented
          mm_task_req_q <= 1'b1;
          timer_q       <= '0;
          rcnt_q        <= '0;
          state_q       <= WAIT;
        end
        WAIT: begin
          if (mm_task_grant) begin
            rcnt_q <= rcnt_q + ONE_IDX;
          end
          if (mm_task_end) begin
            // Preload word 0 now; it bypasses the buffer when it is the
            // word being written this very cycle
            last_q    <= rcnt_q;
            ocnt_q    <= '0;
            m_valid_q <= 1'b1;
            m_data_q  <= (rcnt_q == '0) ? mm_task_res : buf_q[0];
            m_last_q  <= (rcnt_q == '0);
            state_q   <= DRAIN;
          end else if (timer_q == TMO_LAST) begin
            err_q     <= 1'b1;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (ocnt_q == last_q) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              // Fetch the next word on the handshake for zero-bubble output
              ocnt_q   <= ocnt_nxt;
              m_data_q <= buf_q[ocnt_nxt];
              m_last_q <= (ocnt_nxt == last_q);
            end
          end
        end
        default: begin
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign mm_wr_ena   = mm_wr_ena_q;
  assign mm_wr_addr  = mm_wr_addr_q;
  assign mm_wr_x     = mm_wr_x_q;
  assign mm_wr_y     = mm_wr_y_q;
  assign mm_wr_m     = mm_wr_m_q;
  assign mm_wr_m1    = m1_q;
  assign mm_task_req = mm_task_req_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_iddmm_host_if.sv
module tb_iddmm_host_if;
  localparam int K   = 16;
  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [K-1:0]  s_x, s_y, s_m, s_m1;
  logic          s_keep_m;
  logic [2:0]    mm_wr_ena;
  logic [AW-1:0] mm_wr_addr;
  logic [K-1:0]  mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1;
  logic          mm_task_req;
  logic          mm_task_grant, mm_task_end;
  logic [K-1:0]  mm_task_res;
  logic          m_valid, m_ready, m_last, busy, err_timeout;
  logic [K-1:0]  m_data;

  iddmm_host_if #(.K(K), .N(N), .ADDR_W(AW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_m(s_m), .s_m1(s_m1), .s_keep_m(s_keep_m),
    .mm_wr_ena(mm_wr_ena), .mm_wr_addr(mm_wr_addr),
    .mm_wr_x(mm_wr_x), .mm_wr_y(mm_wr_y), .mm_wr_m(mm_wr_m), .mm_wr_m1(mm_wr_m1),
    .mm_task_req(mm_task_req), .mm_task_grant(mm_task_grant),
    .mm_task_end(mm_task_end), .mm_task_res(mm_task_res),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]    ena;
    logic [AW-1:0] addr;
    logic [K-1:0]  x;
    logic [K-1:0]  y;
    logic [K-1:0]  m;
  } wr_t;

  wr_t          wr_q[$];
  logic [K-1:0] res_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0; s_m = '0; s_m1 = '0;
    s_keep_m = 1'b0; mm_task_grant = 1'b0; mm_task_end = 1'b0;
    mm_task_res = '0; m_ready = 1'b0;
    tick; tick;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if ({mm_wr_ena, mm_wr_addr, mm_task_req, m_valid, m_last, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {mm_wr_ena, mm_wr_addr, mm_task_req, m_valid, m_last, err_timeout});
    end
    checks++;
    if ({mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1, m_data} !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", {mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1, m_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Loads one job back-to-back and checks the write stream and task_req
  task automatic load_job(input logic keep, output int req_cyc);
    wr_t e;
    int  nreq = 0;
    int  prev = -10;
    req_cyc = -1;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          s_valid  = 1'b1;
          s_x      = K'(i + 1);
          s_y      = K'(i + 5);
          s_m      = K'(i + 9);
          s_m1     = (i == 0) ? 16'h0033 : 16'h00ff;
          s_keep_m = (i == 0) ? keep : ~keep;
          e.ena = keep ? 3'b011 : 3'b111;
          e.addr = AW'(i); e.x = s_x; e.y = s_y; e.m = s_m;
          wr_q.push_back(e);
          checks++;
          if (s_ready !== 1'b1) begin errors++; $display("FAIL load_ready word %0d got %b want 1", i, s_ready); end
          tick;
        end
        s_valid = 1'b0;
      end
      begin
        for (int c = 0; c < N + 4; c++) begin
          @(negedge clk);
          if (mm_wr_ena !== 3'b000) begin
            checks++;
            if (wr_q.size() == 0) begin
              errors++; $display("FAIL wr_extra got ena %b want none", mm_wr_ena);
            end else begin
              e = wr_q.pop_front();
              if (mm_wr_ena !== e.ena || mm_wr_addr !== e.addr || mm_wr_x !== e.x ||
                  mm_wr_y !== e.y || (e.ena[2] && mm_wr_m !== e.m)) begin
                errors++;
                $display("FAIL wr_word got ena %b addr %0d x %h y %h m %h want ena %b addr %0d x %h y %h m %h",
                         mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, e.ena, e.addr, e.x, e.y, e.m);
              end
              if (prev >= 0 && cyc != prev + 1) begin
                errors++; $display("FAIL wr_gap got cycle %0d want %0d", cyc, prev + 1);
              end
              prev = cyc;
            end
          end
          if (mm_task_req === 1'b1) begin nreq++; req_cyc = cyc; end
        end
      end
    join
    checks++;
    if (wr_q.size() != 0) begin errors++; $display("FAIL wr_missing got %0d left want 0", wr_q.size()); wr_q.delete(); end
    checks++;
    if (nreq != 1) begin errors++; $display("FAIL req_count got %0d want 1", nreq); end
    checks++;
    if (req_cyc != prev + 1) begin errors++; $display("FAIL req_cycle got %0d want %0d", req_cyc, prev + 1); end
    checks++;
    if (mm_wr_m1 !== 16'h0033) begin errors++; $display("FAIL wr_m1 got %h want 0033", mm_wr_m1); end
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err_timeout); end
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL wait_state got busy %b s_ready %b want 1 0", busy, s_ready);
    end
    @(posedge clk); #1;
  endtask

  // Multiplier model: streams N scripted result words, end on the last
  task automatic respond(input logic [K-1:0] base);
    for (int i = 0; i < N; i++) begin
      mm_task_grant = 1'b1;
      mm_task_end   = (i == N - 1);
      mm_task_res   = base + K'(i);
      res_q.push_back(mm_task_res);
      tick;
    end
    mm_task_grant = 1'b0;
    mm_task_end   = 1'b0;
  endtask

  task automatic drain(input logic toggle);
    logic [K-1:0] exp_d;
    int start = -1;
    int done_c = -1;
    for (int c = 0; c < 4 * N + 8 && res_q.size() != 0; c++) begin
      m_ready = toggle ? c[0] : 1'b1;
      @(negedge clk);
      if (m_valid === 1'b1) begin
        if (start < 0) start = cyc;
        checks++;
        if (m_data !== res_q[0] || m_last !== (res_q.size() == 1)) begin
          errors++;
          $display("FAIL drain_word got data %h last %b want data %h last %b",
                   m_data, m_last, res_q[0], (res_q.size() == 1));
        end
        if (m_ready) begin exp_d = res_q.pop_front(); done_c = cyc; end
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    checks++;
    if (res_q.size() != 0) begin errors++; $display("FAIL drain_timeout got %0d left want 0", res_q.size()); res_q.delete(); end
    if (!toggle) begin
      checks++;
      if (done_c - start != N - 1) begin errors++; $display("FAIL drain_bubble got %0d cycles want %0d", done_c - start + 1, N); end
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL drain_idle got valid %b busy %b s_ready %b want 0 0 1", m_valid, busy, s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_stall_drain;
    int r;
    load_job(1'b0, r);
    respond(16'ha000);
    drain(1'b1);
  endtask

  task automatic test_keep_m_back_to_back;
    int r;
    load_job(1'b1, r);
    respond(16'hb000);
    drain(1'b0);
  endtask

  task automatic test_timeout;
    int r;
    int t = -1;
    load_job(1'b0, r);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin t = cyc; break; end
    end
    checks++;
    if (t != r + TMO) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", t, r + TMO); end
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_idle got s_ready %b busy %b want 1 0", s_ready, busy);
    end
    @(posedge clk); #1;
    load_job(1'b0, r);
    respond(16'hc000);
    drain(1'b0);
  endtask

  task automatic test_reset_midjob;
    int r;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_x = K'(16'h70 + i); s_y = K'(16'h80 + i); s_m = K'(16'h90 + i);
      s_m1 = 16'h0055; s_keep_m = 1'b0;
      tick;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    tick;
    @(negedge clk);
    checks++;
    if (mm_wr_ena !== 3'b000 || mm_wr_addr !== '0 || mm_wr_m1 !== '0 || mm_task_req !== 1'b0) begin
      errors++; $display("FAIL midrst_wr got ena %b addr %0d m1 %h req %b want 0", mm_wr_ena, mm_wr_addr, mm_wr_m1, mm_task_req);
    end
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_state got busy %b s_ready %b want 0 1", busy, s_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    load_job(1'b0, r);
    respond(16'hd000);
    drain(1'b1);
    mm_task_grant = 1'b1; mm_task_end = 1'b1; mm_task_res = 16'hffff;
    tick;
    mm_task_grant = 1'b0; mm_task_end = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL stray_grant got valid %b busy %b want 0 0", m_valid, busy);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_load_stall_drain;
    test_keep_m_back_to_back;
    test_timeout;
    test_reset_midjob;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
